// File: rtl/pc_ctrl_unit_if.sv
// Bundle between the decode/datapath side and the PC control unit.
// The master drives the decode and next-PC inputs. The slave is the PC unit.
interface pc_ctrl_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] next_pc_i;
   logic             stall_i;
   logic             flag_we_i;
   logic             alu_zero_i;
   logic             alu_neg_i;
   logic             balrv_i;
   logic             baln_i;
   logic             jsp_i;
   logic             jmxor_i;
   logic             dmem_ready_i;
   logic [WIDTH-1:0] pc_o;
   logic [WIDTH-1:0] pc_plus4_o;
   logic             sel_s1_o;
   logic             sel_s2_o;
   logic             sel_s3_o;
   logic [1:0]       status_o;
   logic             link_we_o;
   logic             misalign_o;
   logic [WIDTH-1:0] retire_cnt_o;

   modport master (
      output next_pc_i, stall_i, flag_we_i, alu_zero_i, alu_neg_i,
             balrv_i, baln_i, jsp_i, jmxor_i, dmem_ready_i,
      input  pc_o, pc_plus4_o, sel_s1_o, sel_s2_o, sel_s3_o,
             status_o, link_we_o, misalign_o, retire_cnt_o
   );

   modport slave (
      input  next_pc_i, stall_i, flag_we_i, alu_zero_i, alu_neg_i,
             balrv_i, baln_i, jsp_i, jmxor_i, dmem_ready_i,
      output pc_o, pc_plus4_o, sel_s1_o, sel_s2_o, sel_s3_o,
             status_o, link_we_o, misalign_o, retire_cnt_o
   );
endinterface

// File: rtl/pc_ctrl_unit.sv
// PC register, {N,Z} status, and next-PC mux select control for the single-cycle core.
// Also covers link write, the jmxor memory wait, and a retired-instruction counter.
module pc_ctrl_unit #(
   parameter int unsigned    WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned    PC_INC   = 4
) (
   input logic              clk,
   input logic              rst_n,
   pc_ctrl_unit_if.slave    bus
);
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] retire_q;
   logic [1:0]       status_q;
   logic             misalign_q;
   logic             advance_c;
   logic             br_z_c;
   logic             br_n_c;

   // A jmxor instruction waits until memory read data is valid.
   assign advance_c = ~bus.stall_i & (~bus.jmxor_i | bus.dmem_ready_i);

   // Selects use only the registered status, so a flag write is seen by the next instruction.
   assign br_z_c = bus.balrv_i & status_q[0];
   assign br_n_c = bus.baln_i  & status_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         retire_q   <= '0;
         status_q   <= 2'b00;
         misalign_q <= 1'b0;
      end else if (advance_c) begin
         pc_q     <= {bus.next_pc_i[WIDTH-1:2], 2'b00};
         retire_q <= retire_q + WIDTH'(1);
         if (bus.flag_we_i) begin
            status_q <= {bus.alu_neg_i, bus.alu_zero_i};
         end
         if (bus.next_pc_i[1:0] != 2'b00) begin
            misalign_q <= 1'b1;
         end
      end
   end

   assign bus.pc_o         = pc_q;
   assign bus.pc_plus4_o   = pc_q + WIDTH'(PC_INC);
   assign bus.sel_s1_o     = br_z_c | bus.jsp_i;
   assign bus.sel_s2_o     = br_n_c;
   assign bus.sel_s3_o     = bus.jmxor_i;
   assign bus.status_o     = status_q;
   assign bus.link_we_o    = advance_c & (br_z_c | br_n_c);
   assign bus.misalign_o   = misalign_q;
   assign bus.retire_cnt_o = retire_q;
endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Directed bench for pc_ctrl_unit: reset, flags/branches, jmxor wait, misalign, wrap, stall.
module tb_pc_ctrl_unit;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   pc_ctrl_unit_if #(.WIDTH(32)) bus ();

   pc_ctrl_unit #(.WIDTH(32), .RESET_PC(32'h0), .PC_INC(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.next_pc_i    = '0;
      bus.stall_i      = 1'b0;
      bus.flag_we_i    = 1'b0;
      bus.alu_zero_i   = 1'b0;
      bus.alu_neg_i    = 1'b0;
      bus.balrv_i      = 1'b0;
      bus.baln_i       = 1'b0;
      bus.jsp_i        = 1'b0;
      bus.jmxor_i      = 1'b0;
      bus.dmem_ready_i = 1'b0;
      tick();
      tick();
      chk("reset_hold_pc", bus.pc_o, 32'h0);
      rst_n = 1'b1;

      // T1: run a little, then reset mid-cycle
      bus.next_pc_i = 32'h4; tick();
      bus.next_pc_i = 32'h8; tick();
      chk("pre_rst_pc", bus.pc_o, 32'h8);
      rst_n = 1'b0;
      #1;
      chk("rst_pc", bus.pc_o, 32'h0);
      chk("rst_status", 32'(bus.status_o), 32'h0);
      chk("rst_cnt", bus.retire_cnt_o, 32'h0);
      #2;
      rst_n = 1'b1;
      bus.next_pc_i = 32'h4;  tick();
      bus.next_pc_i = 32'h8;  tick();
      bus.next_pc_i = 32'hC;  tick();
      chk("t1_pc", bus.pc_o, 32'hC);
      chk("t1_cnt", bus.retire_cnt_o, 32'd3);
      chk("t1_plus4", bus.pc_plus4_o, 32'h10);

      // T2: set Z, then balrv takes the branch with link
      bus.next_pc_i = 32'h10; tick();
      bus.flag_we_i = 1'b1; bus.alu_zero_i = 1'b1; bus.next_pc_i = 32'h14;
      tick();
      chk("t2_status", 32'(bus.status_o), 32'h1);
      bus.flag_we_i = 1'b0; bus.alu_zero_i = 1'b0; bus.balrv_i = 1'b1;
      #1;
      chk("t2_s1_taken", 32'(bus.sel_s1_o), 32'h1);
      chk("t2_link_taken", 32'(bus.link_we_o), 32'h1);
      chk("t2_s2_idle", 32'(bus.sel_s2_o), 32'h0);
      bus.next_pc_i = 32'h80; tick();
      chk("t2_pc", bus.pc_o, 32'h80);
      bus.balrv_i = 1'b0; bus.flag_we_i = 1'b1; bus.next_pc_i = 32'h84;
      tick();
      chk("t2_status_clr", 32'(bus.status_o), 32'h0);
      bus.flag_we_i = 1'b0; bus.balrv_i = 1'b1;
      #1;
      chk("t2_s1_not", 32'(bus.sel_s1_o), 32'h0);
      chk("t2_link_not", 32'(bus.link_we_o), 32'h0);
      bus.balrv_i = 1'b0; bus.jsp_i = 1'b1;
      #1;
      chk("t2_jsp_s1", 32'(bus.sel_s1_o), 32'h1);
      chk("t2_jsp_link", 32'(bus.link_we_o), 32'h0);
      bus.jsp_i = 1'b0;

      // T3: flag write and baln in the same cycle use the old status
      bus.flag_we_i = 1'b1; bus.alu_neg_i = 1'b1; bus.baln_i = 1'b1;
      #1;
      chk("t3_s2_old", 32'(bus.sel_s2_o), 32'h0);
      chk("t3_link_old", 32'(bus.link_we_o), 32'h0);
      bus.next_pc_i = 32'h40; tick();
      chk("t3_status", 32'(bus.status_o), 32'h2);
      chk("t3_pc", bus.pc_o, 32'h40);
      chk("t3_cnt", bus.retire_cnt_o, 32'd8);
      bus.flag_we_i = 1'b0; bus.alu_neg_i = 1'b0;
      #1;
      chk("t3_s2_new", 32'(bus.sel_s2_o), 32'h1);
      chk("t3_link_new", 32'(bus.link_we_o), 32'h1);
      bus.baln_i = 1'b0;

      // T4: jmxor waits on memory ready
      bus.jmxor_i = 1'b1; bus.dmem_ready_i = 1'b0; bus.next_pc_i = 32'h200;
      #1;
      chk("t4_s3", 32'(bus.sel_s3_o), 32'h1);
      bus.baln_i = 1'b1;
      #1;
      chk("t4_wait_link", 32'(bus.link_we_o), 32'h0);
      chk("t4_wait_s2", 32'(bus.sel_s2_o), 32'h1);
      bus.baln_i = 1'b0;
      tick(); tick(); tick();
      chk("t4_hold_pc", bus.pc_o, 32'h40);
      chk("t4_hold_cnt", bus.retire_cnt_o, 32'd8);
      chk("t4_hold_s3", 32'(bus.sel_s3_o), 32'h1);
      bus.dmem_ready_i = 1'b1;
      tick();
      chk("t4_pc", bus.pc_o, 32'h200);
      chk("t4_cnt", bus.retire_cnt_o, 32'd9);
      bus.jmxor_i = 1'b0; bus.dmem_ready_i = 1'b0;

      // T5: misaligned target and PC wrap
      chk("t5_misalign_clr", 32'(bus.misalign_o), 32'h0);
      bus.next_pc_i = 32'h103; tick();
      chk("t5_pc_align", bus.pc_o, 32'h100);
      chk("t5_misalign", 32'(bus.misalign_o), 32'h1);
      bus.next_pc_i = 32'h104; tick();
      chk("t5_sticky", 32'(bus.misalign_o), 32'h1);
      bus.next_pc_i = 32'hFFFF_FFFC; tick();
      chk("t5_pc_top", bus.pc_o, 32'hFFFF_FFFC);
      chk("t5_plus4_wrap", bus.pc_plus4_o, 32'h0);
      chk("t5_cnt", bus.retire_cnt_o, 32'd12);

      // T6: stall blocks PC, status, counter and link
      bus.stall_i = 1'b1; bus.flag_we_i = 1'b1; bus.alu_zero_i = 1'b1;
      bus.baln_i = 1'b1; bus.next_pc_i = 32'h500;
      #1;
      chk("t6_link_stall", 32'(bus.link_we_o), 32'h0);
      tick(); tick();
      chk("t6_pc", bus.pc_o, 32'hFFFF_FFFC);
      chk("t6_status", 32'(bus.status_o), 32'h2);
      chk("t6_cnt", bus.retire_cnt_o, 32'd12);
      chk("t6_link_stall2", 32'(bus.link_we_o), 32'h0);
      bus.stall_i = 1'b0;
      #1;
      chk("t6_link_go", 32'(bus.link_we_o), 32'h1);
      tick();
      chk("t6_pc_go", bus.pc_o, 32'h500);
      chk("t6_status_go", 32'(bus.status_o), 32'h1);
      chk("t6_cnt_go", bus.retire_cnt_o, 32'd13);
      bus.flag_we_i = 1'b0; bus.alu_zero_i = 1'b0; bus.baln_i = 1'b0;

      // Reset during a jmxor wait abandons it
      bus.jmxor_i = 1'b1; bus.dmem_ready_i = 1'b0; bus.next_pc_i = 32'h300;
      tick();
      chk("rw_hold", bus.pc_o, 32'h500);
      rst_n = 1'b0;
      #1;
      chk("rw_pc", bus.pc_o, 32'h0);
      chk("rw_misalign", 32'(bus.misalign_o), 32'h0);
      chk("rw_cnt", bus.retire_cnt_o, 32'h0);
      chk("rw_status", 32'(bus.status_o), 32'h0);
      #2;
      rst_n = 1'b1;
      bus.jmxor_i = 1'b0; bus.next_pc_i = 32'h4;
      tick();
      chk("rw_restart_pc", bus.pc_o, 32'h4);
      chk("rw_restart_cnt", bus.retire_cnt_o, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
